// File: rtl/estat_timer_unit.sv
// ESTAT/ECFG/TCFG/TVAL CSR block with countdown timer, sticky timer interrupt,
// LIE masking and commit-time exception cause capture.
module estat_timer_unit #(
    parameter int NUM_HWI = 8,
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               estat_we,
    input  logic [1:0]         estat_wdata,
    input  logic               ecfg_we,
    input  logic [12:0]        ecfg_wdata,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_we,
    input  logic               ticlr_clr,
    input  logic [NUM_HWI-1:0] hwi,
    input  logic               ipi,
    input  logic               crmd_ie,
    input  logic               exc_commit,
    input  logic [14:0]        exc_vec,
    output logic [31:0]        estat,
    output logic [31:0]        ecfg,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               int_pending,
    output logic               exc_taken,
    output logic               exc_is_int
);

    logic [1:0]  is_sw;
    logic [7:0]  is_hwi;
    logic [7:0]  hwi_ext;
    logic        ti;
    logic        ipi_q;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [12:0] lie;

    assign estat = {1'b0, esubcode, ecode, 3'b000, ipi_q, ti, 1'b0, is_hwi, is_sw};
    assign ecfg  = {19'd0, lie};
    assign int_pending = crmd_ie & (|(estat[12:0] & lie));

    // Unused hardware interrupt lines read as zero.
    always_comb begin
        hwi_ext = '0;
        hwi_ext[NUM_HWI-1:0] = hwi;
    end

    logic               tick;
    logic [TIMER_W-1:0] reload;
    assign reload = {tcfg[TIMER_W-1:2], 2'b00};
    assign tick   = !tcfg_we && tcfg[0] && (tval == TIMER_W'(1));

    // Exception priority encoder: highest set bit of exc_vec wins.
    logic [3:0] win_idx;
    logic [5:0] win_ecode;
    logic [8:0] win_sub;
    always_comb begin
        win_idx = 4'd0;
        for (int i = 0; i < 15; i++)
            if (exc_vec[i]) win_idx = 4'(i);
        win_sub = 9'd0;
        case (win_idx)
            4'd14:   win_ecode = 6'h01;
            4'd13:   win_ecode = 6'h02;
            4'd12:   win_ecode = 6'h03;
            4'd11:   win_ecode = 6'h04;
            4'd10:   win_ecode = 6'h07;
            4'd9:    win_ecode = 6'h08;
            4'd8: begin
                win_ecode = 6'h08;
                win_sub   = 9'd1;
            end
            4'd7:    win_ecode = 6'h09;
            4'd6:    win_ecode = 6'h0B;
            4'd5:    win_ecode = 6'h0C;
            4'd4:    win_ecode = 6'h0D;
            4'd3:    win_ecode = 6'h0E;
            4'd2:    win_ecode = 6'h0F;
            4'd1:    win_ecode = 6'h12;
            default: win_ecode = 6'h3F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_sw  <= '0;
            is_hwi <= '0;
            ipi_q  <= 1'b0;
            lie    <= '0;
        end else begin
            is_hwi <= hwi_ext;
            ipi_q  <= ipi;
            if (estat_we) is_sw <= estat_wdata;
            if (ecfg_we)  lie   <= {ecfg_wdata[12:11], 1'b0, ecfg_wdata[9:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcfg <= '0;
            tval <= '0;
            ti   <= 1'b0;
        end else begin
            if (tcfg_we) begin
                tcfg <= tcfg_wdata;
                tval <= {tcfg_wdata[TIMER_W-1:2], 2'b00};
            end else if (tick) begin
                if (tcfg[1]) begin
                    tval <= reload;
                end else begin
                    tval    <= '0;
                    tcfg[0] <= 1'b0;
                end
            end else if (tcfg[0] && tval > TIMER_W'(1)) begin
                tval <= tval - TIMER_W'(1);
            end
            // A tick in the same cycle as a clear keeps TI set.
            if (tick)
                ti <= 1'b1;
            else if (ticlr_we && ticlr_clr)
                ti <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecode      <= '0;
            esubcode   <= '0;
            exc_taken  <= 1'b0;
            exc_is_int <= 1'b0;
        end else if (exc_commit && int_pending) begin
            ecode      <= '0;
            esubcode   <= '0;
            exc_taken  <= 1'b1;
            exc_is_int <= 1'b1;
        end else if (exc_commit && (|exc_vec)) begin
            ecode      <= win_ecode;
            esubcode   <= win_sub;
            exc_taken  <= 1'b1;
            exc_is_int <= 1'b0;
        end else begin
            exc_taken  <= 1'b0;
            exc_is_int <= 1'b0;
        end
    end

endmodule

// File: tb/tb_estat_timer_unit.sv
// Directed bench for estat_timer_unit: cause-encoding vector table plus
// hand-written timer, interrupt, hwi and reset sequences.
module tb_estat_timer_unit;

    localparam int NH = 4;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          estat_we;
    logic [1:0]    estat_wdata;
    logic          ecfg_we;
    logic [12:0]   ecfg_wdata;
    logic          tcfg_we;
    logic [TW-1:0] tcfg_wdata;
    logic          ticlr_we;
    logic          ticlr_clr;
    logic [NH-1:0] hwi;
    logic          ipi;
    logic          crmd_ie;
    logic          exc_commit;
    logic [14:0]   exc_vec;
    logic [31:0]   estat;
    logic [31:0]   ecfg;
    logic [TW-1:0] tcfg;
    logic [TW-1:0] tval;
    logic          int_pending;
    logic          exc_taken;
    logic          exc_is_int;

    estat_timer_unit #(.NUM_HWI(NH), .TIMER_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .estat_we(estat_we), .estat_wdata(estat_wdata),
        .ecfg_we(ecfg_we), .ecfg_wdata(ecfg_wdata),
        .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .ticlr_clr(ticlr_clr),
        .hwi(hwi), .ipi(ipi), .crmd_ie(crmd_ie),
        .exc_commit(exc_commit), .exc_vec(exc_vec),
        .estat(estat), .ecfg(ecfg), .tcfg(tcfg), .tval(tval),
        .int_pending(int_pending), .exc_taken(exc_taken), .exc_is_int(exc_is_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] vec;
        logic [5:0]  ecode;
        logic [8:0]  esub;
    } vec_t;

    vec_t tbl[18];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{15'h4000, 6'h01, 9'd0};
        tbl[1]  = '{15'h2000, 6'h02, 9'd0};
        tbl[2]  = '{15'h1000, 6'h03, 9'd0};
        tbl[3]  = '{15'h0800, 6'h04, 9'd0};
        tbl[4]  = '{15'h0400, 6'h07, 9'd0};
        tbl[5]  = '{15'h0200, 6'h08, 9'd0};
        tbl[6]  = '{15'h0100, 6'h08, 9'd1};
        tbl[7]  = '{15'h0080, 6'h09, 9'd0};
        tbl[8]  = '{15'h0040, 6'h0B, 9'd0};
        tbl[9]  = '{15'h0020, 6'h0C, 9'd0};
        tbl[10] = '{15'h0010, 6'h0D, 9'd0};
        tbl[11] = '{15'h0008, 6'h0E, 9'd0};
        tbl[12] = '{15'h0004, 6'h0F, 9'd0};
        tbl[13] = '{15'h0002, 6'h12, 9'd0};
        tbl[14] = '{15'h0001, 6'h3F, 9'd0};
        tbl[15] = '{15'h0300, 6'h08, 9'd0};
        tbl[16] = '{15'h0180, 6'h08, 9'd1};
        tbl[17] = '{15'h7FFF, 6'h01, 9'd0};

        rst_n = 1'b0; estat_we = 0; estat_wdata = 0; ecfg_we = 0; ecfg_wdata = 0;
        tcfg_we = 0; tcfg_wdata = 0; ticlr_we = 0; ticlr_clr = 0; hwi = 0; ipi = 0;
        crmd_ie = 0; exc_commit = 0; exc_vec = 0;
        #3;
        chk("rst_estat", estat, 0);
        chk("rst_tval", tval, 0);
        chk("rst_exc_taken", exc_taken, 0);
        #20 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_estat", estat, 0);
            chk("idle_tval", tval, 0);
            chk("idle_int_pending", int_pending, 0);
            chk("idle_exc_taken", exc_taken, 0);
        end

        // Exception cause encoding table
        for (int i = 0; i < 18; i++) begin
            exc_commit = 1; exc_vec = tbl[i].vec;
            step();
            exc_commit = 0; exc_vec = 0;
            chk("tbl_ecode", estat[21:16], tbl[i].ecode);
            chk("tbl_esub", estat[30:22], tbl[i].esub);
            chk("tbl_taken", exc_taken, 1);
            chk("tbl_is_int", exc_is_int, 0);
            step();
            chk("tbl_taken_drop", exc_taken, 0);
            chk("tbl_ecode_hold", estat[21:16], tbl[i].ecode);
        end

        // Periodic timer, InitVal = 2
        tcfg_we = 1; tcfg_wdata = 32'h0000_000B;
        step();
        tcfg_we = 0;
        chk("per_tval_load", tval, 8);
        chk("per_tcfg", tcfg, 32'hB);
        for (int k = 7; k >= 1; k--) begin
            step();
            chk("per_count", tval, k);
            chk("per_ti_low", estat[11], 0);
        end
        step();
        chk("per_tick_reload", tval, 8);
        chk("per_tick_ti", estat[11], 1);
        ticlr_we = 1; ticlr_clr = 1;
        step();
        ticlr_we = 0; ticlr_clr = 0;
        chk("ticlr_clears", estat[11], 0);
        chk("ticlr_tval", tval, 7);
        repeat (6) step();
        chk("per_pre_tick", tval, 1);
        ticlr_we = 1; ticlr_clr = 1;
        step();
        ticlr_we = 0; ticlr_clr = 0;
        chk("tick_beats_clr", estat[11], 1);
        chk("per_tick2_reload", tval, 8);

        // One-shot timer
        ticlr_we = 1; ticlr_clr = 1;
        tcfg_we = 1; tcfg_wdata = 32'h0000_0009;
        step();
        ticlr_we = 0; ticlr_clr = 0; tcfg_we = 0;
        chk("os_tval_load", tval, 8);
        chk("os_ti_clr", estat[11], 0);
        repeat (7) step();
        chk("os_pre_tick", tval, 1);
        step();
        chk("os_tval_zero", tval, 0);
        chk("os_en_clr", tcfg, 32'h8);
        chk("os_ti_set", estat[11], 1);
        repeat (10) step();
        chk("os_tval_hold", tval, 0);
        chk("os_ti_sticky", estat[11], 1);

        // Interrupt vs exception
        ecfg_we = 1; ecfg_wdata = 13'h0800; crmd_ie = 1;
        step();
        ecfg_we = 0;
        chk("ecfg_lie", ecfg, 32'h800);
        chk("int_pending_on", int_pending, 1);
        exc_commit = 1; exc_vec = 15'h0040;
        step();
        exc_commit = 0;
        chk("int_ecode", estat[21:16], 0);
        chk("int_is_int", exc_is_int, 1);
        chk("int_taken", exc_taken, 1);
        crmd_ie = 0;
        #1 chk("int_pending_ie_off", int_pending, 0);
        crmd_ie = 1;
        ecfg_we = 1; ecfg_wdata = 13'h1FFF;
        step();
        chk("ecfg_bit10_zero", ecfg, 32'h1BFF);
        ecfg_wdata = 13'h0000;
        step();
        ecfg_we = 0;
        chk("int_pending_off", int_pending, 0);
        exc_commit = 1;
        step();
        exc_commit = 0; exc_vec = 0;
        chk("noint_ecode", estat[21:16], 6'h0B);
        chk("noint_is_int", exc_is_int, 0);

        // InitVal = 0 with En: holds, never ticks
        ticlr_we = 1; ticlr_clr = 1;
        tcfg_we = 1; tcfg_wdata = 32'h0000_0001;
        step();
        ticlr_we = 0; ticlr_clr = 0; tcfg_we = 0;
        repeat (5) step();
        chk("iv0_tval", tval, 0);
        chk("iv0_no_tick", estat[11], 0);
        chk("iv0_en_kept", tcfg, 32'h1);

        // estat_we and capture in the same cycle
        estat_we = 1; estat_wdata = 2'b11; exc_commit = 1; exc_vec = 15'h0001;
        step();
        estat_we = 0; exc_commit = 0; exc_vec = 0;
        chk("indep_sw", estat[1:0], 2'b11);
        chk("indep_ecode", estat[21:16], 6'h3F);
        estat_we = 1; estat_wdata = 2'b00;
        step();
        estat_we = 0;

        // hwi / ipi registration
        hwi = 4'b1010;
        step();
        chk("hwi_reg", estat[9:2], 8'b0000_1010);
        hwi = 0; ipi = 1;
        step();
        chk("ipi_reg", estat[12], 1);
        chk("hwi_drop", estat[9:2], 0);
        ipi = 0;

        // Mid-count asynchronous reset
        tcfg_we = 1; tcfg_wdata = 32'h0000_000B;
        step();
        tcfg_we = 0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_tval", tval, 0);
        chk("mrst_tcfg", tcfg, 0);
        chk("mrst_estat", estat, 0);
        chk("mrst_ecfg", ecfg, 0);
        chk("mrst_taken", {exc_taken, exc_is_int}, 0);
        #2 rst_n = 1'b1;
        repeat (3) step();
        chk("mrst_timer_stopped", tval, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
